hi_meas_core: RTL and testbench

//   Measurement sequencer that sits directly downstream of home_inventory_wb.
//   On a CTRL.START pulse it collects 2**AVG_LOG2 load-cell samples over a

---
 rtl/hi_core_pkg.sv | 24 ++
 rtl/hi_meas_core_if.sv | 12 +
 rtl/hi_sample_accum.sv | 41 ++++
 rtl/hi_meas_core.sv | 161 ++++++++++++++++
 tb/tb_hi_meas_core.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hi_core_pkg.sv
// Shared encodings for the measurement core: FSM states, STATUS bit
// positions and IRQ source bit positions.
package hi_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_AVG  = 2'd2
    } meas_state_t;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_TMO      = 2;
    localparam int STAT_OVR      = 3;
    localparam int STAT_STATE_LO = 4;
    localparam int STAT_STATE_HI = 5;
    localparam int STAT_RSVD     = 6;
    localparam int STAT_EN       = 7;

    localparam int IRQ_DONE = 0;
    localparam int IRQ_TMO  = 1;
    localparam int IRQ_OVR  = 2;

endpackage

// File: rtl/hi_meas_core_if.sv
// Load-cell sample stream (valid/ready). The ADC side is the master,
// the measurement core is the slave and owns ready.
interface hi_meas_core_if #(
    parameter int SAMPLE_W = 24
);
    logic                adc_valid;
    logic [SAMPLE_W-1:0] adc_data;
    logic                adc_ready;

    modport master (output adc_valid, output adc_data, input adc_ready);
    modport slave  (input adc_valid, input adc_data, output adc_ready);
endinterface

// File: rtl/hi_sample_accum.sv
// Sample accumulator: running sum and sample count for one measurement.
// The accumulator is wide enough to hold 2**AVG_LOG2 full-scale samples.
module hi_sample_accum #(
    parameter int SAMPLE_W = 24,
    parameter int AVG_LOG2 = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         accept,
    input  logic [SAMPLE_W-1:0]          data,
    output logic [SAMPLE_W+AVG_LOG2-1:0] sum,
    output logic                         full
);
    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // sum includes the sample being accepted this cycle, so the final mean
    // can be taken on the same edge as the last accept
    assign sum  = acc + ACC_W'(data);
    assign full = accept && (cnt == CNT_LAST);

    // accumulate accepted samples; clear has priority over accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hi_meas_core.sv
// Measurement sequencer: on a start pulse collects 2**AVG_LOG2 samples and
// publishes their truncated mean, with sticky done/timeout/overrun flags.
//
//   state | meaning
//   IDLE  | waiting for ctrl_start with ctrl_enable high
//   ACQ   | adc_ready high, accepting samples, timeout counter running
//   AVG   | one cycle after the final accept; result_valid high, done set
module hi_meas_core #(
    parameter int SAMPLE_W    = 24,
    parameter int AVG_LOG2    = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                ctrl_enable,
    input  logic                ctrl_start,
    input  logic [2:0]          irq_en,
    hi_meas_core_if.slave       adc,
    output logic [SAMPLE_W-1:0] result,
    output logic                result_valid,
    output logic [7:0]          core_status,
    output logic                irq
);
    import hi_core_pkg::*;

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    // the threshold is hit on the idle cycle that would take tmo to TIMEOUT_CYC-1
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

    meas_state_t      state, state_next;
    logic [TMO_W-1:0] tmo;
    logic             done, timeout, overrun;
    logic             accept, acc_clear, acc_full;
    logic             start_ok, tmo_hit, complete;
    logic [ACC_W-1:0] acc_sum;
    logic [2:0]       flag_vec;

    assign adc.adc_ready = (state == ST_ACQ);
    assign accept        = adc.adc_valid && (state == ST_ACQ);

    hi_sample_accum #(
        .SAMPLE_W (SAMPLE_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (acc_clear),
        .accept (accept),
        .data   (adc.adc_data),
        .sum    (acc_sum),
        .full   (acc_full)
    );

    // state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_next;
    end

    // next state and per-cycle control strobes; abort beats completion and timeout
    always_comb begin
        state_next = state;
        acc_clear  = 1'b0;
        start_ok   = 1'b0;
        tmo_hit    = 1'b0;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl_start && ctrl_enable) begin
                    start_ok   = 1'b1;
                    acc_clear  = 1'b1;
                    state_next = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (!ctrl_enable) begin
                    acc_clear  = 1'b1;
                    state_next = ST_IDLE;
                end else if (acc_full) begin
                    complete   = 1'b1;
                    state_next = ST_AVG;
                end else if (!accept && (tmo == TMO_LAST)) begin
                    tmo_hit    = 1'b1;
                    acc_clear  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_AVG: begin
                acc_clear  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                acc_clear  = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    // idle-cycle counter: restarts on every accept and on every accumulator clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                  tmo <= '0;
        else if (acc_clear || accept)  tmo <= '0;
        else if (state == ST_ACQ)      tmo <= tmo + TMO_W'(1);
    end

    // result is taken from the running sum on the final accept so that it and
    // result_valid appear together in the AVG cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= complete;
            if (complete) result <= SAMPLE_W'(acc_sum >> AVG_LOG2);
        end
    end

    // sticky flags, cleared only by an accepted start
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            overrun <= 1'b0;
        end else if (start_ok) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (state == ST_AVG)                    done    <= 1'b1;
            if (tmo_hit)                            timeout <= 1'b1;
            if (ctrl_start && (state != ST_IDLE))   overrun <= 1'b1;
        end
    end

    // map flags onto their irq_en bit positions
    always_comb begin
        flag_vec           = '0;
        flag_vec[IRQ_DONE] = done;
        flag_vec[IRQ_TMO]  = timeout;
        flag_vec[IRQ_OVR]  = overrun;
    end

    // registered level interrupt
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) irq <= 1'b0;
        else          irq <= |(irq_en & flag_vec);
    end

    // status word; the enable mirror is live even during reset
    always_comb begin
        core_status                              = '0;
        core_status[STAT_BUSY]                   = (state != ST_IDLE);
        core_status[STAT_DONE]                   = done;
        core_status[STAT_TMO]                    = timeout;
        core_status[STAT_OVR]                    = overrun;
        core_status[STAT_STATE_HI:STAT_STATE_LO] = state;
        core_status[STAT_EN]                     = ctrl_enable;
    end

endmodule

// File: tb/tb_hi_meas_core.sv
// Bench for hi_meas_core: randomized sample streams checked against an
// arithmetic mean computed here, plus flag, irq and timing checks.
module tb_hi_meas_core;

    localparam int SW  = 24;
    localparam int AL  = 3;
    localparam int TMO = 16;
    localparam int N   = 1 << AL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctrl_enable = 1'b0;
    logic          ctrl_start  = 1'b0;
    logic [2:0]    irq_en = 3'b000;
    logic [SW-1:0] result;
    logic          result_valid;
    logic [7:0]    core_status;
    logic          irq;

    hi_meas_core_if #(.SAMPLE_W(SW)) adc();

    hi_meas_core #(
        .SAMPLE_W    (SW),
        .AVG_LOG2    (AL),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .ctrl_enable  (ctrl_enable),
        .ctrl_start   (ctrl_start),
        .irq_en       (irq_en),
        .adc          (adc),
        .result       (result),
        .result_valid (result_valid),
        .core_status  (core_status),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            rv_seen = 0;
    longint        sum_model = 0;
    logic [SW-1:0] exp_result = '0;
    logic [SW-1:0] exp_mean;

    task automatic step();
        @(negedge clk);
        if (result_valid === 1'b1) rv_seen++;
    endtask

    task automatic start_meas();
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        sum_model = 0;
    endtask

    task automatic send_sample(input logic [SW-1:0] d, input int gap);
        int guard;
        adc.adc_valid = 1'b0;
        repeat (gap) step();
        adc.adc_valid = 1'b1;
        adc.adc_data  = d;
        guard = 0;
        while (adc.adc_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_bad++;
            $display("FAIL sample_accept: adc_ready stayed %b, required 1 within 50 cycles", adc.adc_ready);
        end
        step();
        sum_model += longint'(d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ctrl_enable = 1'b1;
        #12;
        n_cmp++;
        if (core_status !== 8'h80) begin n_bad++; $display("FAIL reset_status: got %h required 80", core_status); end
        n_cmp++;
        if ({result, result_valid, irq, adc.adc_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: result=%h rv=%b irq=%b ready=%b required all 0", result, result_valid, irq, adc.adc_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        ctrl_enable = 1'b1;
        irq_en = 3'b001;
        start_meas();
        for (int i = 0; i < N; i++) send_sample(SW'(100 + i), 0);
        exp_mean = SW'(sum_model / N);
        n_cmp++;
        if (result_valid !== 1'b1 || result !== exp_mean) begin
            n_bad++;
            $display("FAIL basic_result: rv=%b result=%0d required rv=1 result=%0d", result_valid, result, exp_mean);
        end
        n_cmp++;
        if (result !== 24'd103) begin n_bad++; $display("FAIL basic_103: got %0d required 103", result); end
        adc.adc_valid = 1'b0;
        step();
        n_cmp++;
        if (result_valid !== 1'b0 || core_status[1] !== 1'b1 || core_status[0] !== 1'b0 || result !== exp_mean) begin
            n_bad++;
            $display("FAIL basic_after: rv=%b status=%h result=%0d required rv=0 done=1 busy=0 result=%0d", result_valid, core_status, result, exp_mean);
        end
        step();
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL basic_irq: got %b required 1", irq); end
        exp_result = exp_mean;
    endtask

    task automatic test_gaps();
        irq_en = 3'b010;
        rv_seen = 0;
        start_meas();
        for (int i = 0; i < N; i++) send_sample(24'hFFFFFF, $urandom_range(0, 14));
        exp_mean = SW'(sum_model / N);
        n_cmp++;
        if (result_valid !== 1'b1 || result !== exp_mean || result !== 24'hFFFFFF) begin
            n_bad++;
            $display("FAIL gaps_result: rv=%b result=%h required rv=1 result=%h", result_valid, result, exp_mean);
        end
        adc.adc_valid = 1'b0;
        step();
        n_cmp++;
        if (core_status[2] !== 1'b0 || core_status[1] !== 1'b1 || rv_seen != 1) begin
            n_bad++;
            $display("FAIL gaps_flags: status=%h rv_pulses=%0d required timeout=0 done=1 pulses=1", core_status, rv_seen);
        end
        step();
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL gaps_irq: got %b required 0", irq); end
        exp_result = exp_mean;
    endtask

    task automatic test_timeout();
        irq_en = 3'b000;
        start_meas();
        send_sample(SW'($urandom), 0);
        send_sample(SW'($urandom), 1);
        adc.adc_valid = 1'b0;
        rv_seen = 0;
        repeat (TMO - 2) step();
        n_cmp++;
        if (core_status[5:4] !== 2'd1) begin n_bad++; $display("FAIL tmo_early: state=%0d required 1 after %0d idle", core_status[5:4], TMO - 2); end
        step();
        n_cmp++;
        if (core_status[5:4] !== 2'd0 || core_status[2:0] !== 3'b100) begin
            n_bad++;
            $display("FAIL tmo_flag: status=%h required state=0 timeout=1 done=0 busy=0", core_status);
        end
        n_cmp++;
        if (result !== exp_result || rv_seen != 0) begin
            n_bad++;
            $display("FAIL tmo_result: result=%h pulses=%0d required result=%h pulses=0", result, rv_seen, exp_result);
        end
        step();
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL tmo_irq_masked: got %b required 0", irq); end
        irq_en = 3'b010;
        step();
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL tmo_irq: got %b required 1", irq); end
        irq_en = 3'b101;
        step();
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL tmo_irq_drop: got %b required 0", irq); end
    endtask

    task automatic test_overrun();
        irq_en = 3'b100;
        start_meas();
        for (int i = 0; i < 3; i++) send_sample(SW'($urandom), $urandom_range(0, 3));
        adc.adc_valid = 1'b0;
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
        n_cmp++;
        if (core_status[3] !== 1'b1 || core_status[5:4] !== 2'd1) begin
            n_bad++;
            $display("FAIL ovr_flag: status=%h required overrun=1 state=1", core_status);
        end
        step();
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL ovr_irq: got %b required 1", irq); end
        for (int i = 3; i < N; i++) send_sample(SW'($urandom), $urandom_range(0, 3));
        exp_mean = SW'(sum_model / N);
        n_cmp++;
        if (result_valid !== 1'b1 || result !== exp_mean) begin
            n_bad++;
            $display("FAIL ovr_result: rv=%b result=%h required rv=1 result=%h", result_valid, result, exp_mean);
        end
        adc.adc_valid = 1'b0;
        step();
        n_cmp++;
        if (core_status[3:0] !== 4'b1010) begin n_bad++; $display("FAIL ovr_final: status=%h required [3:0]=1010", core_status); end
        exp_result = exp_mean;
    endtask

    task automatic test_abort();
        irq_en = 3'b111;
        start_meas();
        for (int i = 0; i < 3; i++) send_sample(SW'($urandom), 0);
        adc.adc_valid = 1'b0;
        rv_seen = 0;
        ctrl_enable = 1'b0;
        step();
        n_cmp++;
        if (core_status !== 8'h00) begin n_bad++; $display("FAIL abort_status: got %h required 00", core_status); end
        step();
        n_cmp++;
        if (irq !== 1'b0 || rv_seen != 0 || result !== exp_result) begin
            n_bad++;
            $display("FAIL abort_outputs: irq=%b pulses=%0d result=%h required irq=0 pulses=0 result=%h", irq, rv_seen, result, exp_result);
        end
        start_meas();
        step();
        n_cmp++;
        if (core_status !== 8'h00 || irq !== 1'b0 || adc.adc_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL start_disabled: status=%h irq=%b ready=%b required 00/0/0", core_status, irq, adc.adc_ready);
        end
        ctrl_enable = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        ctrl_enable = 1'b1;
        start_meas();
        send_sample(SW'($urandom), 0);
        send_sample(SW'($urandom), 0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (core_status !== 8'h80 || {result, result_valid, irq, adc.adc_ready} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: status=%h result=%h rv=%b irq=%b ready=%b required 80 and all 0", core_status, result, result_valid, irq, adc.adc_ready);
        end
        adc.adc_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_result = '0;
        step();
        n_cmp++;
        if (core_status !== 8'h80 || result !== exp_result) begin
            n_bad++;
            $display("FAIL midreset_release: status=%h result=%h required 80 / 0", core_status, result);
        end
        test_basic();
    endtask

    initial begin
        adc.adc_valid = 1'b0;
        adc.adc_data  = '0;
        test_reset();
        test_basic();
        test_gaps();
        test_timeout();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
